// File: rtl/digit_memory_bank.sv
// Switch-addressed DEPTH x DATA_W display memory with manual, fill, scan and swept-clear modes.
// Optional per-word write locks are compiled in with `define DIGIT_MEM_LOCK_EN.
module digit_memory_bank #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 3,
  parameter int SCAN_TICKS = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write_push,
  input  logic                  read_push,
  input  logic                  mode_push,
  input  logic                  clear_push,
  input  logic                  lock_push,
  input  logic [ADDR_W-1:0]     switch_address,
  input  logic [DATA_W-1:0]     switch_value,
  output logic [DATA_W-1:0]     indicate_led,
  output logic [1:0]            mode,
  output logic                  busy,
  output logic                  locked,
  output logic [6:0]            digit_addr,
  output logic [7*DATA_W/4-1:0] digit_value
);

  // state   | meaning
  // MANUAL  | switches address the memory directly
  // FILL    | writes land at fill_ptr, which auto-increments
  // SCAN    | every word shown for SCAN_TICKS cycles in turn
  // CLEAR   | one word zeroed per cycle, strobes ignored
  typedef enum logic [1:0] {
    S_MANUAL = 2'd0,
    S_FILL   = 2'd1,
    S_SCAN   = 2'd2,
    S_CLEAR  = 2'd3
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NDIG  = DATA_W / 4;
  localparam int CNT_W = $clog2(SCAN_TICKS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

  function automatic logic [6:0] hex2seven_seg(input logic [3:0] hex);
    logic [6:0] seg;
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   indicating;
  logic [ADDR_W-1:0]   fill_ptr, scan_ptr, clr_ptr, ea;
  logic [CNT_W-1:0]    cnt;
  logic                paused;
  logic                lock_req, lock_go, wr_go, rd_go, ea_locked;

  always_comb begin
    ea = switch_address;
    case (state)
      S_FILL:  ea = fill_ptr;
      S_SCAN:  ea = scan_ptr;
      S_CLEAR: ea = clr_ptr;
      default: ea = switch_address;
    endcase
  end

  // Higher-priority strobes suppress lower ones in the same cycle.
  assign lock_go = lock_req & ~clear_push & ~mode_push;
  assign wr_go   = write_push & ~clear_push & ~mode_push & ~lock_req;
  assign rd_go   = read_push & ~clear_push & ~mode_push & ~lock_req;

`ifdef DIGIT_MEM_LOCK_EN
  logic [DEPTH-1:0] lock_q;

  assign lock_req  = lock_push;
  assign ea_locked = lock_q[ea];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q <= '0;
    end else if (state == S_CLEAR) begin
      lock_q <= '0;
    end else if (lock_go && (state == S_MANUAL || state == S_FILL)) begin
      lock_q[ea] <= ~lock_q[ea];
    end
  end
`else
  logic unused_lock_push;

  assign unused_lock_push = lock_push;
  assign lock_req         = 1'b0;
  assign ea_locked        = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_MANUAL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_CLEAR) begin
      if (clr_ptr == ADDR_LAST) state_nxt = S_MANUAL;
    end else if (clear_push) begin
      state_nxt = S_CLEAR;
    end else if (mode_push) begin
      if (state == S_MANUAL)    state_nxt = S_FILL;
      else if (state == S_FILL) state_nxt = S_SCAN;
      else                      state_nxt = S_MANUAL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      indicating <= '0;
      fill_ptr   <= '0;
      scan_ptr   <= '0;
      clr_ptr    <= '0;
      cnt        <= '0;
      paused     <= 1'b0;
    end else begin
      case (state)
        S_MANUAL: begin
          if (mode_push && !clear_push) fill_ptr <= '0;
          if (rd_go) indicating <= mem[ea];
          if (wr_go && !ea_locked) mem[ea] <= switch_value;
        end
        S_FILL: begin
          if (mode_push && !clear_push) begin
            scan_ptr <= '0;
            cnt      <= '0;
            paused   <= 1'b0;
          end
          if (wr_go) begin
            fill_ptr <= fill_ptr + 1'b1;
            if (!ea_locked) begin
              mem[ea]    <= switch_value;
              indicating <= switch_value;
            end
          end else if (rd_go) begin
            indicating <= mem[ea];
          end
        end
        S_SCAN: begin
          indicating <= mem[scan_ptr];
          if (!paused) begin
            if (cnt == CNT_LAST) begin
              cnt      <= '0;
              scan_ptr <= scan_ptr + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          if (rd_go) paused <= ~paused;
        end
        default: begin
          mem[clr_ptr] <= '0;
          clr_ptr      <= clr_ptr + 1'b1;
          if (clr_ptr == ADDR_LAST) indicating <= '0;
        end
      endcase
    end
  end

  assign indicate_led = indicating;
  assign mode         = state;
  assign busy         = (state == S_CLEAR);
  assign locked       = ea_locked;
  assign digit_addr   = hex2seven_seg(4'(ea));

  for (genvar k = 0; k < NDIG; k++) begin : g_digit
    assign digit_value[7*k +: 7] = hex2seven_seg(indicating[4*k +: 4]);
  end

endmodule

// File: tb/tb_digit_memory_bank.sv
// Randomised and directed bench for digit_memory_bank against an array-level behavioural model.
module tb_digit_memory_bank;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int TICKS  = 4;
  localparam int DEPTH  = 8;
`ifdef DIGIT_MEM_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              write_push = 1'b0, read_push = 1'b0, mode_push = 1'b0;
  logic              clear_push = 1'b0, lock_push = 1'b0;
  logic [ADDR_W-1:0] switch_address = '0;
  logic [DATA_W-1:0] switch_value = '0;
  logic [DATA_W-1:0] indicate_led;
  logic [1:0]        mode;
  logic              busy, locked;
  logic [6:0]        digit_addr;
  logic [13:0]       digit_value;

  digit_memory_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .SCAN_TICKS(TICKS)) dut (
    .clk(clk), .reset(reset),
    .write_push(write_push), .read_push(read_push), .mode_push(mode_push),
    .clear_push(clear_push), .lock_push(lock_push),
    .switch_address(switch_address), .switch_value(switch_value),
    .indicate_led(indicate_led), .mode(mode), .busy(busy), .locked(locked),
    .digit_addr(digit_addr), .digit_value(digit_value)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_tests = 0;
  int n_fail  = 0;

  // Model: 0 manual, 1 fill, 2 scan, 3 clear
  int         m_mode, m_fill, m_scan, m_clr, m_cnt;
  bit         m_paused;
  bit         m_lock [DEPTH];
  logic [7:0] m_mem  [DEPTH];
  logic [7:0] m_ind;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_ea();
    case (m_mode)
      1:       return m_fill;
      2:       return m_scan;
      3:       return m_clr;
      default: return int'(switch_address);
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_fill = 0; m_scan = 0; m_clr = 0; m_cnt = 0;
    m_paused = 1'b0; m_ind = '0;
    for (int i = 0; i < DEPTH; i++) begin m_mem[i] = '0; m_lock[i] = 1'b0; end
  endtask

  task automatic model_step();
    int a;
    a = model_ea();
    if (m_mode == 3) begin
      m_mem[m_clr] = '0;
      for (int i = 0; i < DEPTH; i++) m_lock[i] = 1'b0;
      if (m_clr == DEPTH - 1) begin m_mode = 0; m_clr = 0; m_ind = '0; end
      else m_clr++;
      return;
    end
    if (m_mode == 2) begin
      m_ind = m_mem[m_scan];
      if (!m_paused) begin
        m_cnt++;
        if (m_cnt == TICKS) begin m_cnt = 0; m_scan = (m_scan + 1) % DEPTH; end
      end
    end
    if (clear_push) begin
      m_mode = 3; m_clr = 0;
    end else if (mode_push) begin
      if (m_mode == 0)      begin m_mode = 1; m_fill = 0; end
      else if (m_mode == 1) begin m_mode = 2; m_scan = 0; m_cnt = 0; m_paused = 1'b0; end
      else                  m_mode = 0;
    end else if (LOCK_EN && lock_push) begin
      if (m_mode < 2) m_lock[a] = !m_lock[a];
    end else if (m_mode == 0) begin
      if (read_push) m_ind = m_mem[a];
      if (write_push && !m_lock[a]) m_mem[a] = switch_value;
    end else if (m_mode == 1) begin
      if (write_push) begin
        if (!m_lock[a]) begin m_mem[a] = switch_value; m_ind = switch_value; end
        m_fill = (m_fill + 1) % DEPTH;
      end else if (read_push) begin
        m_ind = m_mem[a];
      end
    end else begin
      if (read_push) m_paused = !m_paused;
    end
  endtask

  task automatic compare();
    int a;
    logic [13:0] dv;
    a = model_ea();
    for (int k = 0; k < 2; k++) dv[7*k +: 7] = seg_tab[m_ind[4*k +: 4]];
    chk("indicate_led", indicate_led, m_ind);
    chk("mode", mode, m_mode);
    chk("busy", busy, m_mode == 3);
    chk("locked", locked, m_lock[a]);
    chk("digit_addr", digit_addr, seg_tab[a]);
    chk("digit_value", digit_value, dv);
  endtask

  always @(negedge clk) begin
    #1;
    if (reset) model_reset();
    compare();
    if (!reset) model_step();
  end

  task automatic drive(input bit wp, input bit rp, input bit mp, input bit cp, input bit lp,
                       input int a, input int v);
    @(negedge clk);
    write_push = wp; read_push = rp; mode_push = mp; clear_push = cp; lock_push = lp;
    switch_address = a[ADDR_W-1:0];
    switch_value   = v[DATA_W-1:0];
  endtask

  task automatic idle();
    @(negedge clk);
    write_push = 1'b0; read_push = 1'b0; mode_push = 1'b0; clear_push = 1'b0; lock_push = 1'b0;
  endtask

  initial begin
    int busy_cycles;
    int r;
    bit wp, rp, mp, cp, lp;

    idle(); #2;
    chk("reset_led", indicate_led, 8'h00);
    chk("reset_mode", mode, 2'd0);
    chk("reset_busy", busy, 1'b0);
    idle();
    reset = 1'b0;

    // Manual write then read
    drive(1, 0, 0, 0, 0, 5, 8'hA5);
    drive(0, 1, 0, 0, 0, 5, 0);
    idle(); #2;
    chk("manual_read", indicate_led, 8'hA5);
    chk("manual_daddr", digit_addr, 7'h6D);
    chk("manual_dval", digit_value, {7'h77, 7'h6D});

    // Fill with wrap
    drive(0, 0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) drive(1, 0, 0, 0, 0, 0, k * 17);
    idle(); #2;
    chk("fill_mode", mode, 2'd1);
    chk("fill_led", indicate_led, 8'h99);
    chk("fill_ptr_wrap", digit_addr, 7'h06);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(); #2;
    chk("read_addr0", indicate_led, 8'h99);
    drive(0, 1, 0, 0, 0, 1, 0);
    idle(); #2;
    chk("read_addr1", indicate_led, 8'h22);

    // Scan, pause, resume, ignored write
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    repeat (7) idle();
    #2;
    chk("scan_step", indicate_led, 8'h22);
    chk("scan_daddr", digit_addr, 7'h06);
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (10) idle();
    #2;
    chk("scan_paused", indicate_led, 8'h33);
    chk("scan_paused_addr", digit_addr, 7'h5B);
    drive(1, 0, 0, 0, 0, 0, 8'hEE);
    drive(0, 1, 0, 0, 0, 0, 0);
    repeat (40) idle();

    // Clear from scan, write during busy
    drive(0, 0, 0, 1, 0, 0, 0);
    busy_cycles = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i == 2, 0, 0, 0, 0, 3, 8'h55);
      #2;
      busy_cycles += int'(busy);
    end
    idle(); #2;
    chk("clear_busy_cycles", busy_cycles, 8);
    chk("clear_mode", mode, 2'd0);
    chk("clear_led", indicate_led, 8'h00);
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 1, 0, 0, 0, a, 0);
      idle(); #2;
      chk("clear_read", indicate_led, 8'h00);
    end

    // Coincident strobes, then async reset mid-clear
    drive(1, 0, 1, 1, 0, 4, 8'h3C);
    idle(); #2;
    chk("coinc_mode", mode, 2'd3);
    chk("coinc_busy", busy, 1'b1);
    idle(); idle();
    #3 reset = 1'b1;
    #1;
    chk("async_busy", busy, 1'b0);
    chk("async_mode", mode, 2'd0);
    idle(); idle();
    reset = 1'b0;

`ifdef DIGIT_MEM_LOCK_EN
    drive(1, 0, 0, 0, 0, 2, 8'h5A);
    drive(0, 0, 0, 0, 1, 2, 0);
    drive(1, 0, 0, 0, 0, 2, 8'h7E);
    drive(0, 1, 0, 0, 0, 2, 0);
    idle(); #2;
    chk("lock_write_blocked", indicate_led, 8'h5A);
    chk("lock_status", locked, 1'b1);
    drive(0, 0, 0, 1, 0, 2, 0);
    repeat (10) idle();
    drive(0, 1, 0, 0, 0, 2, 0);
    idle(); #2;
    chk("lock_cleared_mem", indicate_led, 8'h00);
    chk("lock_cleared", locked, 1'b0);
`endif

    // Random traffic
    repeat (3000) begin
      r  = $urandom_range(0, 99);
      cp = (r < 1);
      mp = (r >= 1 && r < 5);
      lp = (r >= 5 && r < 10);
      wp = (r >= 10 && r < 35);
      rp = (r >= 35 && r < 50);
      if ($urandom_range(0, 31) == 0) begin
        mp = $urandom_range(0, 1) != 0;
        lp = $urandom_range(0, 1) != 0;
        wp = 1'b1;
      end
      if (wp && rp) rp = 1'b0;
      drive(wp, rp, mp, cp, lp, $urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
    end
    repeat (3) idle();
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_memory_bank.md
Name: digit_memory_bank

Overview:
- Parametrised successor of the 8x8 switch-addressed display memory: DEPTH x DATA_W register file written and read from board switches via debounced one-cycle push strobes.
- Adds three operating modes (manual, sequential fill, auto-scan) and a swept clear.
- Drives LEDs plus seven-segment digits for the active address and the displayed word.
- Sits at board top level, fed by the existing button debouncers; decodes through the existing hex2seven_seg instances.

Parameters:
- DATA_W, 8, word width; multiple of 4, range 4..16; NDIG = DATA_W/4 value digits.
- ADDR_W, 3, address width, range 1..4; DEPTH = 2**ADDR_W (localparam).
- SCAN_TICKS, 50000000, clk cycles each word is shown in SCAN mode; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- write_push  in  1  one-cycle write strobe (debounced).
- read_push  in  1  one-cycle read/pause strobe.
- mode_push  in  1  one-cycle mode-advance strobe.
- clear_push  in  1  one-cycle clear-all strobe.
- lock_push  in  1  one-cycle lock-toggle strobe; used only with the optional feature.
- switch_address  in  ADDR_W  manual address.
- switch_value  in  DATA_W  write data.
- indicate_led  out  DATA_W  displayed word.
- mode  out  2  current state: 0 MANUAL, 1 FILL, 2 SCAN, 3 CLEAR.
- busy  out  1  high while in CLEAR.
- locked  out  1  lock status of the effective address.
- digit_addr  out  7  segments of the effective address, zero-extended to 4 bits.
- digit_value  out  7*NDIG  segments; nibble k drives bits [7k+6:7k].

Behaviour:
- Reset (async, active-high): all memory words = 0, indicating = 0, mode = MANUAL, fill_ptr = scan_ptr = clr_ptr = 0, tick counter = 0, paused = 0, busy = 0, all locks cleared.
- indicate_led = indicating register.
- Digits are combinational from registers through hex2seven_seg, so they follow their registers with no extra latency.
- Effective address (ea): MANUAL → switch_address; FILL → fill_ptr; SCAN → scan_ptr; CLEAR → clr_ptr.
- Strobe priority per cycle: clear_push > mode_push > lock_push > write_push/read_push. A lower-priority strobe coinciding with a higher one is dropped.
- mode_push cycles MANUAL → FILL → SCAN → MANUAL.
  - Entering FILL sets fill_ptr = 0.
  - Entering SCAN sets scan_ptr = 0, counter = 0, paused = 0.
- MANUAL:
  - write_push: mem[switch_address] <= switch_value at the clock edge; indicating unchanged.
  - read_push: indicating <= mem[switch_address]; visible the cycle after the strobe.
- FILL:
  - write_push: mem[fill_ptr] <= switch_value, indicating <= switch_value, fill_ptr <= fill_ptr+1, wrapping DEPTH-1 → 0.
  - read_push: indicating <= mem[fill_ptr], pointer unchanged.
- SCAN:
  - indicating <= mem[scan_ptr] every cycle.
  - When not paused: counter increments; at SCAN_TICKS-1 the counter returns to 0 and scan_ptr increments, wrapping.
  - read_push toggles paused; the counter holds while paused.
  - write_push is ignored.
- CLEAR:
  - Entered from any state on clear_push.
  - Each cycle writes mem[clr_ptr] <= 0 and increments clr_ptr; all locks are cleared; busy = 1.
  - After exactly DEPTH cycles: MANUAL, clr_ptr = 0, indicating = 0, busy = 0.
  - All strobes, including clear_push, are ignored while in CLEAR.
- Reads return pre-write contents; no write-to-read bypass within a cycle.
- Reset asserted mid-CLEAR or mid-SCAN immediately forces the reset state.

Optional Feature:
- DIGIT_MEM_LOCK_EN defined:
  - One lock bit per word.
  - lock_push toggles lock[ea] in MANUAL or FILL only; ignored in SCAN and CLEAR.
  - A write to a locked word is discarded. In FILL, fill_ptr still advances and indicating is unchanged.
  - locked = lock[ea].
  - CLEAR zeroes locked words too and clears all locks.
- Not defined: no lock storage; lock_push ignored; locked tied 0.

Test Plan:
- Defaults: MANUAL, write 0xA5 to addr 5 → read_push at addr 5 → indicate_led = 0xA5 next cycle; digit_addr = "5"; digit_value = "A","5".
- FILL: write 0x11, 0x22, …, 0x99 (9 writes, DEPTH = 8) → fill_ptr wraps to 1; mem[0] = 0x99, mem[1] = 0x22; MANUAL read of addr 0 = 0x99.
- SCAN with SCAN_TICKS = 4: indicate_led steps through mem[0..7] every 4 cycles, then wraps to mem[0].
  - read_push pauses with the word held; a second read_push resumes.
  - write_push in SCAN leaves memory unchanged.
- clear_push during SCAN: busy = 1 for exactly 8 cycles; then mode = 0, indicate_led = 0, every address reads 0; write_push during busy has no effect.
- Same-cycle clear_push + mode_push + write_push → CLEAR entered, write dropped. Async reset pulse mid-CLEAR → busy = 0 and mode = 0 without waiting for a clock edge.
- DIGIT_MEM_LOCK_EN: lock addr 2, write 0x7E to it → mem[2] unchanged, locked = 1; CLEAR → locked = 0 and mem[2] = 0.
